// File: rtl/addac_bist.sv
// addac_bist: on-chip self-test sequencer for the combinational addac block.
//
// Plays a DEPTH-entry table of 7-bit vectors {a,b,c,d,e,saida1,saida2} into
// addac and checks its two outputs one clock period after each drive. The
// mismatch count, the index of the first failure, and pass/done status are
// reported.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   begin a run (accepted in IDLE or DONE only)
//   vec_we     in   table write enable (ignored while a run is active)
//   vec_waddr  in   table write index
//   vec_wdata  in   table write data {a,b,c,d,e,saida1,saida2}
//   dut_in     out  registered {a,b,c,d,e} to addac
//   saida1     in   addac output 1
//   saida2     in   addac output 2
//   busy       out  run in progress (DRIVE or SAMPLE)
//   done       out  run finished, results stable
//   pass       out  done with zero mismatches
//   err_count  out  saturating mismatch count
//   fail_seen  out  at least one mismatch in the current/last run
//   first_fail out  index of first mismatching vector
//
//   state  | meaning
//   IDLE   | waiting for start, table writable
//   DRIVE  | load dut_in/expected bits from table[idx]
//   SAMPLE | addac has settled; compare outputs, advance idx
//   DONE   | results held, table writable, start reruns

module addac_bist #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            vec_we,
  input  logic [AW-1:0]   vec_waddr,
  input  logic [6:0]      vec_wdata,
  output logic [4:0]      dut_in,
  input  logic            saida1,
  input  logic            saida2,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            fail_seen,
  output logic [AW-1:0]   first_fail
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      exp_q, exp_d;
  logic [4:0]      dut_in_q, dut_in_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            fail_seen_q, fail_seen_d;
  logic [AW-1:0]   first_fail_q, first_fail_d;

  logic [6:0]      table_q [DEPTH];
  logic [6:0]      rd_vec;
  logic            tbl_wr;
  logic            mismatch;

  // Table is writable only while no run is using it; not reset so a
  // reset mid-run keeps the loaded vectors.
  assign tbl_wr = vec_we && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      table_q[vec_waddr] <= vec_wdata;
    end
  end

  assign rd_vec = table_q[idx_q];

  // 4-state compare so X/Z from addac is reported as a failure.
  assign mismatch = ({saida1, saida2} !== exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      exp_q        <= '0;
      dut_in_q     <= '0;
      err_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      dut_in_q     <= dut_in_d;
      err_q        <= err_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    dut_in_d     = dut_in_q;
    err_d        = err_q;
    fail_seen_d  = fail_seen_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d        = '0;
          err_d        = '0;
          fail_seen_d  = 1'b0;
          first_fail_d = '0;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        dut_in_d = rd_vec[6:2];
        exp_d    = rd_vec[1:0];
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != {ERRW{1'b1}}) begin
            err_d = err_q + ERRW'(1);
          end
          if (!fail_seen_q) begin
            fail_seen_d  = 1'b1;
            first_fail_d = idx_q;
          end
        end
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in     = dut_in_q;
  assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == '0);
  assign err_count  = err_q;
  assign fail_seen  = fail_seen_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_addac_bist.sv
// Bench for addac_bist: a behavioural addac feeds the DUT outputs back, and a
// reference model predicts the run results straight from the table contents.
module tb_addac_bist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start3;
  logic       vec_we, vec_we3;
  logic [4:0] vec_waddr;
  logic [6:0] vec_wdata;

  logic [4:0] dut_in, dut_in3;
  logic       saida1, saida2, s31, s32;
  logic       busy, done, pass, fail_seen;
  logic       busy3, done3, pass3, fail_seen3;
  logic [7:0] err_count;
  logic [2:0] err_count3;
  logic [4:0] first_fail, first_fail3;

  int tests = 0;
  int fails = 0;

  logic [6:0] tbl  [32];
  logic [6:0] tbl3 [32];
  logic [6:0] rt   [32];

  always #5 clk = ~clk;

  // Behavioural addac: parity of all inputs and a carry-like term.
  function automatic logic [1:0] addac_f(input logic [4:0] v);
    return {^v, (v[4] & v[3]) | (v[2] & v[1]) | v[0]};
  endfunction

  assign {saida1, saida2} = addac_f(dut_in);
  assign {s31, s32}       = addac_f(dut_in3);

  addac_bist dut (
    .clk(clk), .reset(reset), .start(start), .vec_we(vec_we),
    .vec_waddr(vec_waddr), .vec_wdata(vec_wdata), .dut_in(dut_in),
    .saida1(saida1), .saida2(saida2), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_seen(fail_seen), .first_fail(first_fail)
  );

  addac_bist #(.DEPTH(32), .AW(5), .ERRW(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .vec_we(vec_we3),
    .vec_waddr(vec_waddr), .vec_wdata(vec_wdata), .dut_in(dut_in3),
    .saida1(s31), .saida2(s32), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .fail_seen(fail_seen3), .first_fail(first_fail3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every entry whose stored expected bits disagree with addac
  // is a failure; count saturates at sat.
  task automatic ref_run(input int sat, output int ec, output int ff, output bit fs);
    ec = 0; ff = 0; fs = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (rt[i][1:0] != addac_f(rt[i][6:2])) begin
        if (ec < sat) ec++;
        if (!fs) begin fs = 1'b1; ff = i; end
      end
    end
  endtask

  task automatic load(input bit to3);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      vec_waddr = 5'(i);
      vec_wdata = to3 ? tbl3[i] : tbl[i];
      if (to3) vec_we3 = 1'b1; else vec_we = 1'b1;
    end
    @(negedge clk);
    vec_we = 1'b0; vec_we3 = 1'b0;
  endtask

  // mode 0: plain run, 1: start/write pulses mid-run, 2: reset at vector 10
  // SAMPLE, 3: start together with a write to index 0.
  task automatic run(input string tag, input int mode, input logic [6:0] wd);
    int k, ec, ff;
    bit fs, busy_bad, din_bad;
    @(negedge clk);
    start = 1'b1;
    if (mode == 3) begin vec_we = 1'b1; vec_waddr = 5'd0; vec_wdata = wd; end
    @(posedge clk); #1;
    start = 1'b0; vec_we = 1'b0;
    chk({tag, ".clr"}, {23'd0, err_count, fail_seen}, 32'd0);
    chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    k = 0; busy_bad = 0; din_bad = 0;
    while (k < 200) begin
      @(posedge clk); k++; #1;
      if (mode == 1 && k == 10) begin
        start = 1'b1; vec_we = 1'b1; vec_waddr = 5'd3; vec_wdata = tbl[3] ^ 7'h03;
      end else if (mode == 1 && k == 12) begin
        start = 1'b0; vec_we = 1'b0;
      end
      if (mode == 2 && k == 21) begin
        chk({tag, ".pre_rst_err"}, {24'd0, err_count}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk({tag, ".rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".rst_vals"}, {14'd0, dut_in, done, pass, err_count, fail_seen, first_fail}, 32'd0);
        #1 reset = 1'b0;
        return;
      end
      if (done) break;
      if (!busy) busy_bad = 1;
      if (k < 64 && (k % 2) == 1 && dut_in !== tbl[(k - 1) / 2][6:2]) din_bad = 1;
    end
    chk({tag, ".cycles"}, 32'(k), 32'd64);
    chk({tag, ".busy_run"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, ".dut_in"}, {31'd0, din_bad}, 32'd0);
    rt = tbl;
    ref_run(255, ec, ff, fs);
    chk({tag, ".err"}, {24'd0, err_count}, 32'(ec));
    chk({tag, ".fseen"}, {31'd0, fail_seen}, {31'd0, fs});
    chk({tag, ".ffail"}, {27'd0, first_fail}, 32'(ff));
    chk({tag, ".pass"}, {30'd0, done, pass}, {30'd0, 1'b1, ec == 0});
  endtask

  initial begin
    int k3;
    logic [6:0] nv;
    reset = 1'b1; start = 0; start3 = 0; vec_we = 0; vec_we3 = 0;
    vec_waddr = '0; vec_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.vals", {14'd0, dut_in, done, pass, err_count, fail_seen, first_fail}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      nv[6:2] = 5'($urandom);
      nv[1:0] = addac_f(nv[6:2]);
      tbl[i]  = nv;
    end
    load(0);
    run("clean", 0, 7'd0);

    tbl[5][1:0]  = ~tbl[5][1:0];
    tbl[20][1:0] = ~tbl[20][1:0];
    load(0);
    run("err2", 0, 7'd0);
    run("disturb", 1, 7'd0);
    run("rerun", 0, 7'd0);

    repeat (5) @(negedge clk);
    chk("hold", {22'd0, done, err_count, first_fail}, {22'd0, 1'b1, 8'd2, 5'd5});

    run("abort", 2, 7'd0);
    chk("abort.idle", {30'd0, busy, done}, 32'd0);
    run("after_rst", 0, 7'd0);

    nv[6:2] = 5'($urandom);
    nv[1:0] = ~addac_f(nv[6:2]);
    tbl[0] = nv;
    chk("start_we.prep", {31'd0, done}, 32'd1);
    // Drop back to IDLE so the combined start+write happens from IDLE.
    @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
    run("start_we", 3, nv);

    for (int i = 0; i < 32; i++) tbl[i] = 7'($urandom);
    load(0);
    run("random", 0, 7'd0);

    for (int i = 0; i < 32; i++) begin
      nv[6:2] = 5'($urandom);
      nv[1:0] = ~addac_f(nv[6:2]);
      tbl3[i] = nv;
    end
    load(1);
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    k3 = 0;
    while (!done3 && k3 < 200) begin @(negedge clk); k3++; end
    chk("sat.done", {31'd0, done3}, 32'd1);
    chk("sat.err", {29'd0, err_count3}, 32'd7);
    chk("sat.ffail", {26'd0, fail_seen3, first_fail3}, {26'd0, 1'b1, 5'd0});
    chk("sat.pass", {31'd0, pass3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addac_bist.md
# addac_bist

Hardware self-test sequencer that sits directly upstream of the combinational `addac` block. It holds a 32-entry table of 7-bit test vectors and drives `addac` inputs `a..e` from it. It samples `saida1`/`saida2` back and compares them against the expected bits, then reports an error count, the first failing index and pass/done status. It replaces simulation-only vector playback with an on-chip checker usable on the board.

## Interface
Parameters:
- `DEPTH`, 32, number of vectors; power of two, at least 2.
- `AW`, 5, index width, equal to log2(DEPTH).
- `ERRW`, 8, width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `vec_we`  in  1  vector table write enable.
- `vec_waddr`  in  AW  vector table write index.
- `vec_wdata`  in  7  vector, packed as {a,b,c,d,e,saida1,saida2}, MSB first.
- `dut_in`  out  5  registered {a,b,c,d,e} to `addac`.
- `saida1`  in  1  `addac` output 1.
- `saida2`  in  1  `addac` output 2.
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count`==0.
- `err_count`  out  ERRW  mismatch count, saturating.
- `fail_seen`  out  1  at least one mismatch in the current or last run.
- `first_fail`  out  AW  index of the first mismatching vector; valid when `fail_seen`=1.

## Operation
- Vector table: DEPTH x 7 register array with combinational read at `idx`. It is not cleared by reset. A write occurs on a rising edge when `vec_we`=1 and the state is IDLE or DONE; writes in DRIVE/SAMPLE are dropped.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with `start`=1: `idx`<=0, `err_count`<=0, `fail_seen`<=0, `first_fail`<=0, then go to DRIVE. `start`=0 holds the current state.
- DRIVE:
  - `dut_in`<=table[idx][6:2] and `exp`<=table[idx][1:0].
  - Go to SAMPLE.
- SAMPLE: `dut_in` is held and compared as {saida1,saida2} !== `exp`.
  - On mismatch, `err_count` increments and saturates at 2^ERRW-1.
  - On the first mismatch only, `first_fail`<=idx and `fail_seen`<=1.
  - If `idx`==DEPTH-1, go to DONE. Otherwise `idx`<=idx+1 and go to DRIVE.
- DONE: results are held stable until the next `start`.
- `start` in DRIVE/SAMPLE is ignored. The run is not restarted.
- `vec_we` and `start` on the same edge in IDLE: the write completes and the run starts. If the write targets index 0, the new data is used by the first DRIVE.
- X/Z on `saida1`/`saida2` counts as a mismatch, because the compare is 4-state `!==`.

## Timing
- Reset values: state IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_seen`=0, `first_fail`=0, `idx`=0, `exp`=0.
- Reset asserted mid-run aborts immediately to IDLE with the values above. Table contents are retained.
- Start is accepted at edge S. Vector i is driven from edge S+1+2i and compared at edge S+2+2i.
- `addac` therefore gets one full clock period to settle before each compare.
- DONE is entered at edge S+2·DEPTH, which is edge S+64 for the default depth. `done`, `pass` and the final `err_count` are valid from that edge.
- All outputs are registered or decoded from the state register only. There is no combinational path from `saida*` to any output.
- `pass` = `done` & (`err_count`==0).

## Test plan
- Load 32 vectors whose expected bits match a behavioural `addac` model, then pulse `start` -> `busy`=1 for 64 cycles. Required: `done`=1 and `pass`=1, `err_count`=0, `fail_seen`=0.
- Same table with expected bits inverted at indices 5 and 20 -> `err_count`=2, `fail_seen`=1, `first_fail`=5, `pass`=0.
- Build with ERRW=3 and invert all 32 expected entries -> `err_count` saturates at 7, `first_fail`=0.
- Pulse `start` and `vec_we` (index 3, new data) during a run -> run still ends at cycle 64 with unchanged results. Re-reading through a second run shows index 3 unchanged.
- From DONE with errors, pulse `start` -> `err_count`/`fail_seen` clear on that edge and the run repeats identically.
- Assert `reset` asynchronously mid-SAMPLE at vector 10 -> all outputs go to their reset values immediately, without waiting for a clock edge. Required after release: a new `start` runs the full table, which was retained, and gives the original result.
